rd_collector: RTL
=================

RD_COLLECTOR -- requirements
Module: rd_collector

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 64, DQ bus width; one burst is 8*DQ_WIDTH = 512 bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, host read-back FIFO entries; power of two, range 2..64.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 dfi_rddata_valid  in  1  PHY read beat valid, 4*DQ_WIDTH bits per beat.
REQ-006 dfi_rddata_valid_even  in  1  beat belongs to a burst started in slot 0.
REQ-007 dfi_rddata_valid_odd  in  1  beat belongs to a periodic (calibration) read.
REQ-008 dfi_rddata  in  4*DQ_WIDTH  read data beat.
REQ-009 rdback_valid  out  1  FIFO head holds a host burst.
REQ-010 rdback_ready  in  1  host accepts head when high with rdback_valid.
REQ-011 rdback_data  out  8*DQ_WIDTH  assembled burst, beat 0 in bits [4*DQ_WIDTH-1:0].
REQ-012 pr_rd_done  out  1  one-cycle pulse per completed periodic-read burst.
REQ-013 err_overflow  out  1  sticky; host burst dropped on full FIFO.
REQ-014 err_split  out  1  sticky; burst ended after one beat or tag changed mid-burst.
REQ-015 err_clr  in  1  clears both sticky errors.

Function
REQ-016 Assembly FSM SHALL have states IDLE and BEAT1.
REQ-017 IDLE, valid=1: SHALL latch beat into lower half, latch tags (even, odd), go BEAT1.
REQ-018 BEAT1, valid=1, tags equal latched: SHALL form 512-bit burst (new beat upper half), return IDLE.
REQ-019 BEAT1, valid=0 or tags differ: SHALL set err_split, discard partial; if valid=1 the beat SHALL be treated as a new beat 0 (stay BEAT1, relatch).
REQ-020 Completed burst with odd=1 SHALL assert pr_rd_done in the following cycle and SHALL NOT enter the FIFO.
REQ-021 Completed burst with odd=0 SHALL be written to the FIFO in the following cycle; rdback_valid visible one cycle after write (3 cycles min from beat 0).
REQ-022 FIFO full at write time: burst SHALL be dropped, err_overflow set; FIFO contents unchanged.
REQ-023 Simultaneous write and pop with FIFO full SHALL drop the new burst (full evaluated before pop).
REQ-024 Simultaneous write and pop on non-full FIFO SHALL keep occupancy constant.
REQ-025 Pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap bit; full = indices equal, wrap bits differ.
REQ-026 rdback_data SHALL be stable while rdback_valid=1 and rdback_ready=0.
REQ-027 err_clr and a new error in the same cycle: error SHALL remain set.

Reset
REQ-028 rst_n low SHALL force FSM IDLE, FIFO empty, rdback_valid=0, pr_rd_done=0, err_overflow=0, err_split=0, counters 0; rdback_data value don't-care.
REQ-029 Reset mid-burst SHALL discard the partial burst without error.

Configuration
REQ-030 Macro RD_COLLECTOR_STATS_EN defined: SHALL add outputs stat_host_bursts[31:0] and stat_pr_bursts[31:0], counting completed host (including dropped) and periodic bursts, saturating at all-ones.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all else identical.

Structure
REQ-032 Shared package SHALL hold FSM state encoding (IDLE=0, BEAT1=1) and burst-width constant BURST_BITS = 8*DQ_WIDTH.
REQ-033 FIFO SHALL be a sub-module rdback_fifo (synchronous, single clock, valid/ready pop); the assembly FSM stays in rd_collector.

Verification
REQ-034 Two valid beats A,B even=1 odd=0, ready=1 -> rdback_data={B,A}, rdback_valid one cycle, 3 cycles after A.
REQ-035 Two beats odd=1 -> pr_rd_done single pulse, rdback_valid stays 0.
REQ-036 ready=0, 9 host bursts (DEPTH=8) -> 8 stored in order, 9th dropped, err_overflow=1; err_clr -> 0.
REQ-037 One beat, valid low next cycle -> err_split=1, no FIFO write, no pr_rd_done.
REQ-038 rst_n low after beat 0, then release, then two beats C,D -> rdback_data={D,C}, err_split=0.
REQ-039 With RD_COLLECTOR_STATS_EN, 3 host + 2 periodic bursts -> stat_host_bursts=3, stat_pr_bursts=2.

Source files
------------

// File: rtl/rd_collector_pkg.sv
// Shared definitions for the read-data collector: assembly FSM encoding
// and burst geometry helpers.
package rd_collector_pkg;

    // Assembly FSM: IDLE waits for beat 0, BEAT1 waits for beat 1.
    typedef enum logic {
        IDLE  = 1'b0,
        BEAT1 = 1'b1
    } asm_state_e;

    localparam int DQ_WIDTH_DEF = 64;
    localparam int BURST_BITS   = 8 * DQ_WIDTH_DEF;

    // A burst is two PHY beats of 4*DQ_WIDTH each.
    function automatic int burst_bits(input int dq_width);
        return 8 * dq_width;
    endfunction

endpackage

// File: rtl/rd_collector_if.sv
// PHY read-beat input and host read-back handshake of the read-data collector.
interface rd_collector_if
    import rd_collector_pkg::*;
#(
    parameter int DQ_WIDTH = 64
);
    logic                            dfi_rddata_valid;
    logic                            dfi_rddata_valid_even;
    logic                            dfi_rddata_valid_odd;
    logic [4*DQ_WIDTH-1:0]           dfi_rddata;
    logic                            rdback_valid;
    logic                            rdback_ready;
    logic [burst_bits(DQ_WIDTH)-1:0] rdback_data;

    // Environment side: drives PHY beats and host ready.
    modport master (
        output dfi_rddata_valid, dfi_rddata_valid_even, dfi_rddata_valid_odd,
        output dfi_rddata, rdback_ready,
        input  rdback_valid, rdback_data
    );

    // Collector side.
    modport slave (
        input  dfi_rddata_valid, dfi_rddata_valid_even, dfi_rddata_valid_odd,
        input  dfi_rddata, rdback_ready,
        output rdback_valid, rdback_data
    );
endinterface

// File: rtl/rdback_fifo.sv
// Host read-back FIFO. Single clock, write dropped when full (full is judged
// before any same-cycle pop), valid/ready pop with head read combinationally
// so the head stays stable while it waits.
module rdback_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_full,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push, pop;

    assign wr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign push     = wr_en && !wr_full;
    assign pop      = rd_valid && rd_ready;

    // Pointer update; the wrap bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rd_collector.sv
// Read-data collector: pairs PHY read beats into bursts, routes periodic
// (calibration) bursts to a done pulse and host bursts into a read-back FIFO.
// Optional macro RD_COLLECTOR_STATS_EN adds saturating burst counters.
module rd_collector
    import rd_collector_pkg::*;
#(
    parameter int DQ_WIDTH   = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rd_collector_if.slave rd,
    output logic          pr_rd_done,
    output logic          err_overflow,
    output logic          err_split,
    input  logic          err_clr
`ifdef RD_COLLECTOR_STATS_EN
    ,
    output logic [31:0]   stat_host_bursts,
    output logic [31:0]   stat_pr_bursts
`endif
);
    localparam int BEAT_W  = 4 * DQ_WIDTH;
    localparam int BURST_W = burst_bits(DQ_WIDTH);

    asm_state_e          state_q, state_d;
    logic                latch0, complete, split, tags_match;
    logic [BEAT_W-1:0]   beat0_q;
    logic                tag_even_q, tag_odd_q;
    logic [BURST_W-1:0]  burst_q;
    logic                burst_vld_q, burst_odd_q;
    logic                wr_en, fifo_full;

    assign tags_match = (rd.dfi_rddata_valid_even == tag_even_q) &&
                        (rd.dfi_rddata_valid_odd  == tag_odd_q);

    // Assembly FSM next state; a broken burst flags a split and a valid
    // beat that broke it restarts as a fresh beat 0.
    always_comb begin
        state_d  = state_q;
        latch0   = 1'b0;
        complete = 1'b0;
        split    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd.dfi_rddata_valid) begin
                    latch0  = 1'b1;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (rd.dfi_rddata_valid && tags_match) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    split = 1'b1;
                    if (rd.dfi_rddata_valid) begin
                        latch0  = 1'b1;
                        state_d = BEAT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Beat 0 data and its tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat0_q    <= '0;
            tag_even_q <= 1'b0;
            tag_odd_q  <= 1'b0;
        end else if (latch0) begin
            beat0_q    <= rd.dfi_rddata;
            tag_even_q <= rd.dfi_rddata_valid_even;
            tag_odd_q  <= rd.dfi_rddata_valid_odd;
        end
    end

    // Completed-burst stage: feeds the FIFO write and the periodic done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q     <= '0;
            burst_vld_q <= 1'b0;
            burst_odd_q <= 1'b0;
            pr_rd_done  <= 1'b0;
        end else begin
            burst_vld_q <= complete;
            burst_odd_q <= tag_odd_q;
            pr_rd_done  <= complete && tag_odd_q;
            if (complete) burst_q <= {rd.dfi_rddata, beat0_q};
        end
    end

    assign wr_en = burst_vld_q && !burst_odd_q;

    // Sticky errors; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_split    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_split    <= (err_split && !err_clr) || split;
            err_overflow <= (err_overflow && !err_clr) || (wr_en && fifo_full);
        end
    end

`ifdef RD_COLLECTOR_STATS_EN
    // Saturating burst counters; host count includes bursts later dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_host_bursts <= '0;
            stat_pr_bursts   <= '0;
        end else if (complete) begin
            if (tag_odd_q) begin
                if (stat_pr_bursts != '1) stat_pr_bursts <= stat_pr_bursts + 1'b1;
            end else begin
                if (stat_host_bursts != '1) stat_host_bursts <= stat_host_bursts + 1'b1;
            end
        end
    end
`endif

    rdback_fifo #(
        .WIDTH (BURST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (burst_q),
        .wr_full  (fifo_full),
        .rd_valid (rd.rdback_valid),
        .rd_ready (rd.rdback_ready),
        .rd_data  (rd.rdback_data)
    );

endmodule
